// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types and constants for the receive window controller
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLDOFF = 3'd1,
        LISTEN  = 3'd2,
        RECEIVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_TIMEOUT = 2'd1,
        STATUS_SHORT   = 2'd2,
        STATUS_ABORT   = 2'd3
    } status_t;

    // CRC-16/CCITT; a frame carrying its complemented CRC leaves this residue
    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rx_window_controller_if.sv
// rtl/rx_window_controller_if.sv - link between the window controller and the preamble detector
//  master (controller): drives det_rst, det_in_dat/det_in_vld; receives det_out_dat/det_out_vld,
//                       det_bank, det_preamble
//  slave  (detector)  : the mirror image
interface rx_window_controller_if #(
    parameter int BANK_WIDTH = 2
);
    logic                  det_rst;
    logic                  det_in_dat;
    logic                  det_in_vld;
    logic                  det_out_dat;
    logic                  det_out_vld;
    logic [BANK_WIDTH-1:0] det_bank;
    logic                  det_preamble;

    modport master (
        output det_rst, det_in_dat, det_in_vld,
        input  det_out_dat, det_out_vld, det_bank, det_preamble
    );

    modport slave (
        input  det_rst, det_in_dat, det_in_vld,
        output det_out_dat, det_out_vld, det_bank, det_preamble
    );
endinterface

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC-16/CCITT (MSB-first), clear/enable/bit in, crc out
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : reload preset (has priority over enable)
//  enable     : shift bit_in into the register this cycle
//  crc        : current register value
import rx_ctrl_pkg::*;

module crc16_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic feedback;
    assign feedback = crc[15] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_PRESET;
        end else if (clear) begin
            crc <= CRC_PRESET;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end
endmodule

// File: rtl/rx_window_controller.sv
// rtl/rx_window_controller.sv - sequences one tag-reply receive session around the preamble detector
//  clk, rst_n          : clock, asynchronous active-low reset (release synchronised internally)
//  start, abort        : begin session (IDLE only) / abandon session (HOLDOFF, LISTEN, RECEIVE)
//  rx_len              : expected reply bits, captured on accepted start (0 means 1)
//  busy                : high outside IDLE
//  samp_dat, samp_vld  : demodulated samples, forwarded to the detector while it is armed
//  det                 : detector link (reset, gated samples in, bits/bank/preamble out)
//  bit_dat, bit_vld    : forwarded reply bits
//  bank, bit_count     : bank latched at preamble, bits forwarded; held until next start
//  done, status        : one-cycle end-of-session pulse with 0 OK, 1 TIMEOUT, 2 SHORT, 3 ABORT
//  crc_ok              : only with RX_CRC16_EN defined; CRC residue check, valid with done
import rx_ctrl_pkg::*;

module rx_window_controller #(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 64,
    parameter int LEN_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  rx_len,
    output logic                  busy,
    input  logic                  samp_dat,
    input  logic                  samp_vld,
    rx_window_controller_if.master det,
    output logic                  bit_dat,
    output logic                  bit_vld,
    output logic [BANK_WIDTH-1:0] bank,
    output logic [LEN_WIDTH-1:0]  bit_count,
    output logic                  done,
    output logic [1:0]            status
`ifdef RX_CRC16_EN
    ,
    output logic                  crc_ok
`endif
);
    localparam int CNT_MAX = max3(HOLDOFF_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    // Asynchronous assertion, release aligned to clk
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    state_t                state;
    status_t               status_q;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [LEN_WIDTH-1:0]  rx_len_q;
    logic                  det_rst_q;
    logic                  det_in_dat_q;
    logic                  det_in_vld_q;
    logic                  take_bit;
    logic                  last_bit;

    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign take_bit = (state == RECEIVE) && !abort && det.det_out_vld && (bit_count < rx_len_q);
    assign last_bit = (bit_count == rx_len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= IDLE;
            status_q     <= STATUS_OK;
            cnt          <= '0;
            rx_len_q     <= '0;
            bit_count    <= '0;
            bank         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bit_dat      <= 1'b0;
            bit_vld      <= 1'b0;
            det_rst_q    <= 1'b1;
            det_in_dat_q <= 1'b0;
            det_in_vld_q <= 1'b0;
        end else begin
            done         <= 1'b0;
            bit_vld      <= 1'b0;
            det_in_dat_q <= 1'b0;
            det_in_vld_q <= 1'b0;

            case (state)
                IDLE: begin
                    det_rst_q <= 1'b1;
                    if (start) begin
                        state     <= HOLDOFF;
                        busy      <= 1'b1;
                        rx_len_q  <= (rx_len == '0) ? LEN_WIDTH'(1) : rx_len;
                        bit_count <= '0;
                        bank      <= '0;
                        cnt       <= '0;
                    end
                end

                HOLDOFF: begin
                    if (abort) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        status_q <= STATUS_ABORT;
                    end else if (cnt == HOLDOFF_LAST) begin
                        state     <= LISTEN;
                        cnt       <= '0;
                        det_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                LISTEN: begin
                    if (abort) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        status_q  <= STATUS_ABORT;
                        det_rst_q <= 1'b1;
                    end else begin
                        det_in_dat_q <= samp_dat;
                        det_in_vld_q <= samp_vld;
                        // preamble is tested first so it wins over a coincident timeout
                        if (det.det_preamble) begin
                            state <= RECEIVE;
                            bank  <= det.det_bank;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            status_q     <= STATUS_TIMEOUT;
                            det_rst_q    <= 1'b1;
                            det_in_vld_q <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                RECEIVE: begin
                    if (abort) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        status_q  <= STATUS_ABORT;
                        det_rst_q <= 1'b1;
                    end else begin
                        // the detector keeps needing samples to decode reply bits
                        det_in_dat_q <= samp_dat;
                        det_in_vld_q <= samp_vld;
                        if (det.det_out_vld) begin
                            // a bit arriving resets the gap timer, so the final bit beats gap expiry
                            cnt <= '0;
                            if (take_bit) begin
                                bit_vld   <= 1'b1;
                                bit_dat   <= det.det_out_dat;
                                bit_count <= bit_count + LEN_WIDTH'(1);
                                if (last_bit) begin
                                    state        <= DONE;
                                    done         <= 1'b1;
                                    status_q     <= STATUS_OK;
                                    det_rst_q    <= 1'b1;
                                    det_in_vld_q <= 1'b0;
                                end
                            end
                        end else if (cnt == GAP_LAST && bit_count < rx_len_q) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            status_q     <= STATUS_SHORT;
                            det_rst_q    <= 1'b1;
                            det_in_vld_q <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    det_rst_q <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    det_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign status         = status_q;
    assign det.det_rst    = det_rst_q;
    assign det.det_in_dat = det_in_dat_q;
    assign det.det_in_vld = det_in_vld_q;

`ifdef RX_CRC16_EN
    logic [15:0] crc_val;

    crc16_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .clear  ((state == IDLE) && start),
        .enable (take_bit),
        .bit_in (det.det_out_dat),
        .crc    (crc_val)
    );

    // register already holds every forwarded bit by the time done is high
    assign crc_ok = (crc_val == CRC_RESIDUE);
`endif

endmodule
